// File: rtl/one_counter_core.sv
// Gate-level 3-input population count (full-adder structure).
// Purely combinational; every primitive carries #GATE_DELAY
// (simulation only, ignored by synthesis).
//
// Ports:
//   a, b, c : input bits to count
//   s0      : sum bit (a ^ b ^ c)
//   s1      : carry bit (majority of a, b, c)
`timescale 1ns/1ps
module one_counter_core #(
    parameter int unsigned GATE_DELAY = 0
) (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s0,
    output logic s1
);

    logic ab_x;
    logic ab_a;
    logic bc_a;
    logic ac_a;

    // Sum path: two XOR levels.
    xor #(GATE_DELAY) u_x0 (ab_x, a, b);
    xor #(GATE_DELAY) u_x1 (s0, ab_x, c);

    // Carry path: AND level feeding a 3-input OR (majority).
    and #(GATE_DELAY) u_a0 (ab_a, a, b);
    and #(GATE_DELAY) u_a1 (bc_a, b, c);
    and #(GATE_DELAY) u_a2 (ac_a, a, c);
    or  #(GATE_DELAY) u_o0 (s1, ab_a, bc_a, ac_a);

endmodule

// File: rtl/gate_level_one_counter.sv
// Registered 3-input ones-counter.
// The gate-level core produces {s1, s0} = a + b + c; the result is
// captured once per rising clk edge, giving one cycle of latency.
//
// Ports:
//   clk   : system clock, rising-edge active
//   rst_n : synchronous active-low reset (clears y0/y1)
//   a,b,c : data bits to count
//   y0    : registered LSB of the count
//   y1    : registered MSB of the count
`timescale 1ns/1ps
module gate_level_one_counter #(
    parameter int unsigned GATE_DELAY = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic a,
    input  logic b,
    input  logic c,
    output logic y0,
    output logic y1
);

    logic s0;
    logic s1;

    one_counter_core #(
        .GATE_DELAY(GATE_DELAY)
    ) u_core (
        .a  (a),
        .b  (b),
        .c  (c),
        .s0 (s0),
        .s1 (s1)
    );

    // Reset takes priority over the incoming count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y0 <= 1'b0;
            y1 <= 1'b0;
        end else begin
            y0 <= s0;
            y1 <= s1;
        end
    end

endmodule

// File: tb/tb_gate_level_one_counter.sv
`timescale 1ns/1ps
module tb_gate_level_one_counter;

    logic clk;
    logic rst_n;
    logic a;
    logic b;
    logic c;
    logic y0_z;
    logic y1_z;
    logic y0_d;
    logic y1_d;

    int checks;
    int errors;

    // Zero-delay instance.
    gate_level_one_counter #(
        .GATE_DELAY(0)
    ) dut_zero (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .c     (c),
        .y0    (y0_z),
        .y1    (y1_z)
    );

    // 5 ns per gate against the 40 ns clock.
    gate_level_one_counter #(
        .GATE_DELAY(5)
    ) dut_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .c     (c),
        .y0    (y0_d),
        .y1    (y1_d)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0;
        {a, b, c} = 3'b111;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({y1_z, y0_z} !== 2'b00) begin
                errors++;
                $display("FAIL reset_hold_zero[%0d]: got %b, expected 00", i, {y1_z, y0_z});
            end
            checks++;
            if ({y1_d, y0_d} !== 2'b00) begin
                errors++;
                $display("FAIL reset_hold_dly[%0d]: got %b, expected 00", i, {y1_d, y0_d});
            end
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({y1_z, y0_z} !== 2'b11) begin
            errors++;
            $display("FAIL reset_release_zero: got %b, expected 11", {y1_z, y0_z});
        end
        checks++;
        if ({y1_d, y0_d} !== 2'b11) begin
            errors++;
            $display("FAIL reset_release_dly: got %b, expected 11", {y1_d, y0_d});
        end
    endtask

    task automatic test_sequence();
        logic [2:0] pat [7];
        logic [1:0] exp [7];
        pat = '{3'b010, 3'b000, 3'b011, 3'b010, 3'b100, 3'b110, 3'b010};
        exp = '{2'b01,  2'b00,  2'b10,  2'b01,  2'b01,  2'b10,  2'b01};
        for (int i = 0; i < 7; i++) begin
            {a, b, c} = pat[i];
            @(posedge clk);
            #1;
            checks++;
            if ({y1_z, y0_z} !== exp[i]) begin
                errors++;
                $display("FAIL seq_zero[%0d] abc=%b: got %b, expected %b", i, pat[i], {y1_z, y0_z}, exp[i]);
            end
            checks++;
            if ({y1_d, y0_d} !== exp[i]) begin
                errors++;
                $display("FAIL seq_dly[%0d] abc=%b: got %b, expected %b", i, pat[i], {y1_d, y0_d}, exp[i]);
            end
        end
    endtask

    task automatic test_exhaustive();
        // Index is {a,b,c}; entries are the hand-written popcounts.
        logic [1:0] exp [8];
        exp = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
        for (int unsigned i = 0; i < 8; i++) begin
            {a, b, c} = 3'(i);
            @(posedge clk);
            #1;
            checks++;
            if ({y1_z, y0_z} !== exp[i]) begin
                errors++;
                $display("FAIL exh_zero abc=%b: got %b, expected %b", 3'(i), {y1_z, y0_z}, exp[i]);
            end
            checks++;
            if ({y1_d, y0_d} !== exp[i]) begin
                errors++;
                $display("FAIL exh_dly abc=%b: got %b, expected %b", 3'(i), {y1_d, y0_d}, exp[i]);
            end
        end
    endtask

    task automatic test_glitch();
        {a, b, c} = 3'b000;
        @(posedge clk);
        #1;
        checks++;
        if ({y1_z, y0_z} !== 2'b00) begin
            errors++;
            $display("FAIL glitch_base: got %b, expected 00", {y1_z, y0_z});
        end
        // Pulse a high mid-cycle; the delayed core still settles before the edge.
        #9  a = 1'b1;
        #10;
        checks++;
        if ({y1_z, y0_z} !== 2'b00) begin
            errors++;
            $display("FAIL glitch_mid_zero: got %b, expected 00", {y1_z, y0_z});
        end
        checks++;
        if ({y1_d, y0_d} !== 2'b00) begin
            errors++;
            $display("FAIL glitch_mid_dly: got %b, expected 00", {y1_d, y0_d});
        end
        a = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({y1_z, y0_z} !== 2'b00) begin
            errors++;
            $display("FAIL glitch_after_zero: got %b, expected 00", {y1_z, y0_z});
        end
        checks++;
        if ({y1_d, y0_d} !== 2'b00) begin
            errors++;
            $display("FAIL glitch_after_dly: got %b, expected 00", {y1_d, y0_d});
        end
    endtask

    task automatic test_reset_midstream();
        {a, b, c} = 3'b111;
        @(posedge clk);
        #1;
        checks++;
        if ({y1_z, y0_z} !== 2'b11) begin
            errors++;
            $display("FAIL mid_pre: got %b, expected 11", {y1_z, y0_z});
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({y1_z, y0_z} !== 2'b00) begin
            errors++;
            $display("FAIL mid_reset_zero: got %b, expected 00", {y1_z, y0_z});
        end
        checks++;
        if ({y1_d, y0_d} !== 2'b00) begin
            errors++;
            $display("FAIL mid_reset_dly: got %b, expected 00", {y1_d, y0_d});
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({y1_z, y0_z} !== 2'b11) begin
            errors++;
            $display("FAIL mid_release_zero: got %b, expected 11", {y1_z, y0_z});
        end
        checks++;
        if ({y1_d, y0_d} !== 2'b11) begin
            errors++;
            $display("FAIL mid_release_dly: got %b, expected 11", {y1_d, y0_d});
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        {a, b, c} = 3'b111;
        test_reset();
        test_sequence();
        test_exhaustive();
        test_glitch();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
